// File: rtl/nibble_packer.sv
// nibble_packer
//   Reassembles a valid/ready stream of 4-bit nibbles into bytes. Each pair of
//   accepted nibbles becomes one byte, presented together with the mod-16 sum
//   of the two nibbles. A frame that closes on the first nibble of a pair
//   drops that nibble and flags odd_error for one cycle.
//
// Parameters
//   HIGH_FIRST  1: first nibble of a pair -> byte[7:4]; 0: first -> byte[3:0]
//   COUNT_W     width of byte_count
//
// Ports
//   clock       single clock, all logic on posedge
//   reset       synchronous, active-high
//   in_valid    in_nibble/in_last valid
//   in_ready    packer accepts a nibble this cycle
//   in_nibble   nibble data
//   in_last     nibble is the final one of a frame
//   out_valid   out_byte/out_sum/out_last valid
//   out_ready   consumer accepts the byte this cycle
//   out_byte    assembled byte
//   out_sum     (hi + lo) mod 16
//   out_last    byte closes a frame
//   odd_error   1-cycle pulse: frame ended on the first nibble of a pair
//   byte_count  bytes handed off since reset, wraps
module nibble_packer #(
  parameter bit HIGH_FIRST = 1'b1,
  parameter int COUNT_W    = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [3:0]         in_nibble,
  input  logic               in_last,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [7:0]         out_byte,
  output logic [3:0]         out_sum,
  output logic               out_last,
  output logic               odd_error,
  output logic [COUNT_W-1:0] byte_count
);

  typedef enum logic {
    WAIT_FIRST  = 1'b0,
    WAIT_SECOND = 1'b1
  } state_t;

  state_t             state_reg;
  logic [3:0]         held_reg;
  logic               out_valid_reg;
  logic [7:0]         out_byte_reg;
  logic [3:0]         out_sum_reg;
  logic               out_last_reg;
  logic               odd_error_reg;
  logic [COUNT_W-1:0] byte_count_reg;

  logic [7:0]         byte_next;
  logic [3:0]         sum_next;
  logic               in_fire;
  logic               out_fire;

  // The first nibble of a pair never needs the output slot, so it can be
  // taken even while a byte is stalled. The second nibble must wait until
  // the slot is empty or being emptied this cycle.
  assign in_ready = (state_reg == WAIT_FIRST) | ~out_valid_reg | out_ready;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid_reg & out_ready;

  // Byte assembly: place held/incoming nibbles per HIGH_FIRST, bit by bit.
  for (genvar gi = 0; gi < 4; gi++) begin : g_byte
    assign byte_next[gi]     = HIGH_FIRST ? in_nibble[gi] : held_reg[gi];
    assign byte_next[gi + 4] = HIGH_FIRST ? held_reg[gi]  : in_nibble[gi];
  end

  // Carry out of the nibble add is intentionally discarded.
  assign sum_next = held_reg + in_nibble;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg      <= WAIT_FIRST;
      held_reg       <= 4'h0;
      out_valid_reg  <= 1'b0;
      out_byte_reg   <= 8'h00;
      out_sum_reg    <= 4'h0;
      out_last_reg   <= 1'b0;
      odd_error_reg  <= 1'b0;
      byte_count_reg <= '0;
    end else begin
      odd_error_reg <= 1'b0;

      // Drain first; a same-cycle reload below overrides out_valid back to 1.
      if (out_fire) begin
        out_valid_reg  <= 1'b0;
        byte_count_reg <= byte_count_reg + 1'b1;
      end

      if (in_fire) begin
        case (state_reg)
          WAIT_FIRST: begin
            if (in_last) begin
              odd_error_reg <= 1'b1;
            end else begin
              held_reg  <= in_nibble;
              state_reg <= WAIT_SECOND;
            end
          end
          WAIT_SECOND: begin
            out_byte_reg  <= byte_next;
            out_sum_reg   <= sum_next;
            out_last_reg  <= in_last;
            out_valid_reg <= 1'b1;
            state_reg     <= WAIT_FIRST;
          end
          default: state_reg <= WAIT_FIRST;
        endcase
      end
    end
  end

  assign out_valid  = out_valid_reg;
  assign out_byte   = out_byte_reg;
  assign out_sum    = out_sum_reg;
  assign out_last   = out_last_reg;
  assign odd_error  = odd_error_reg;
  assign byte_count = byte_count_reg;

endmodule

// File: tb/tb_nibble_packer.sv
// Testbench for nibble_packer. Two instances share one stimulus stream:
//   dut_a: HIGH_FIRST=1, COUNT_W=8
//   dut_b: HIGH_FIRST=0, COUNT_W=2 (swapped byte, wrapping counter)
module tb_nibble_packer;

  logic       clk = 1'b0;
  logic       srst;
  logic       in_valid;
  logic [3:0] in_nibble;
  logic       in_last;
  logic       out_ready;

  logic       in_ready_a, out_valid_a, out_last_a, odd_error_a;
  logic [7:0] out_byte_a, byte_count_a;
  logic [3:0] out_sum_a;

  logic       in_ready_b, out_valid_b, out_last_b, odd_error_b;
  logic [7:0] out_byte_b;
  logic [3:0] out_sum_b;
  logic [1:0] byte_count_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nibble_packer #(.HIGH_FIRST(1'b1), .COUNT_W(8)) dut_a (
    .clock(clk), .reset(srst),
    .in_valid(in_valid), .in_ready(in_ready_a), .in_nibble(in_nibble), .in_last(in_last),
    .out_valid(out_valid_a), .out_ready(out_ready), .out_byte(out_byte_a),
    .out_sum(out_sum_a), .out_last(out_last_a), .odd_error(odd_error_a),
    .byte_count(byte_count_a)
  );

  nibble_packer #(.HIGH_FIRST(1'b0), .COUNT_W(2)) dut_b (
    .clock(clk), .reset(srst),
    .in_valid(in_valid), .in_ready(in_ready_b), .in_nibble(in_nibble), .in_last(in_last),
    .out_valid(out_valid_b), .out_ready(out_ready), .out_byte(out_byte_b),
    .out_sum(out_sum_b), .out_last(out_last_b), .odd_error(odd_error_b),
    .byte_count(byte_count_b)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One row = inputs for one cycle + in_ready before the edge + outputs after it.
  typedef struct {
    bit         v;
    logic [3:0] n;
    bit         l;
    bit         r;
    bit         ir;
    bit         ov;
    logic [7:0] b;   // expected byte for HIGH_FIRST=1
    logic [3:0] s;
    bit         lst;
    bit         odd;
    logic [7:0] cnt; // expected count for COUNT_W=8
  } vec_t;

  vec_t vecs[15];

  task automatic drive(input bit v, input logic [3:0] n, input bit l, input bit r);
    @(negedge clk);
    in_valid  = v;
    in_nibble = n;
    in_last   = l;
    out_ready = r;
    #1;
  endtask

  task automatic check_outputs(input string tag, input bit ov, input logic [7:0] b,
                               input logic [3:0] s, input bit lst, input bit odd,
                               input logic [7:0] cnt);
    logic [7:0] bsw;
    bsw = {b[3:0], b[7:4]};
    check({tag, " out_valid_a"}, 16'(out_valid_a), 16'(ov));
    check({tag, " out_valid_b"}, 16'(out_valid_b), 16'(ov));
    check({tag, " odd_error_a"}, 16'(odd_error_a), 16'(odd));
    check({tag, " odd_error_b"}, 16'(odd_error_b), 16'(odd));
    check({tag, " byte_count_a"}, 16'(byte_count_a), 16'(cnt));
    check({tag, " byte_count_b"}, 16'(byte_count_b), 16'(cnt[1:0]));
    if (ov) begin
      check({tag, " out_byte_a"}, 16'(out_byte_a), 16'(b));
      check({tag, " out_byte_b"}, 16'(out_byte_b), 16'(bsw));
      check({tag, " out_sum_a"}, 16'(out_sum_a), 16'(s));
      check({tag, " out_sum_b"}, 16'(out_sum_b), 16'(s));
      check({tag, " out_last_a"}, 16'(out_last_a), 16'(lst));
      check({tag, " out_last_b"}, 16'(out_last_b), 16'(lst));
    end
  endtask

  task automatic step(input string tag, input bit v, input logic [3:0] n, input bit l,
                      input bit r, input bit ir, input bit ov, input logic [7:0] b,
                      input logic [3:0] s, input bit lst, input bit odd, input logic [7:0] cnt);
    drive(v, n, l, r);
    check({tag, " in_ready_a"}, 16'(in_ready_a), 16'(ir));
    check({tag, " in_ready_b"}, 16'(in_ready_b), 16'(ir));
    @(posedge clk);
    #1;
    check_outputs(tag, ov, b, s, lst, odd, cnt);
    $display("%s: v=%0d n=%h l=%0d r=%0d -> ov=%0d byte=%h/%h sum=%h last=%0d odd=%0d cnt=%0d/%0d",
             tag, v, n, l, r, out_valid_a, out_byte_a, out_byte_b, out_sum_a, out_last_a,
             odd_error_a, byte_count_a, byte_count_b);
  endtask

  initial begin
    //          v  n     l  r  ir ov b      s     lst odd cnt
    // basic pair A,5 then sum overflow 9,8
    vecs[0]  = '{1, 4'hA, 0, 1, 1, 0, 8'h00, 4'h0, 0, 0, 8'd0};
    vecs[1]  = '{1, 4'h5, 1, 1, 1, 1, 8'hA5, 4'hF, 1, 0, 8'd0};
    vecs[2]  = '{1, 4'h9, 0, 1, 1, 0, 8'h00, 4'h0, 0, 0, 8'd1};
    vecs[3]  = '{1, 4'h8, 0, 1, 1, 1, 8'h98, 4'h1, 0, 0, 8'd1};
    vecs[4]  = '{0, 4'h0, 0, 1, 1, 0, 8'h00, 4'h0, 0, 0, 8'd2};
    // backpressure: 3,C held, 7 accepted, D blocked, then simultaneous drain+reload
    vecs[5]  = '{1, 4'h3, 0, 0, 1, 0, 8'h00, 4'h0, 0, 0, 8'd2};
    vecs[6]  = '{1, 4'hC, 0, 0, 1, 1, 8'h3C, 4'hF, 0, 0, 8'd2};
    vecs[7]  = '{1, 4'h7, 0, 0, 1, 1, 8'h3C, 4'hF, 0, 0, 8'd2};
    vecs[8]  = '{1, 4'hD, 1, 0, 0, 1, 8'h3C, 4'hF, 0, 0, 8'd2};
    vecs[9]  = '{1, 4'hD, 1, 1, 1, 1, 8'h7D, 4'h4, 1, 0, 8'd3};
    vecs[10] = '{0, 4'h0, 0, 1, 1, 0, 8'h00, 4'h0, 0, 0, 8'd4};
    // odd frame: 1,2(last) then lone 6(last) dropped with odd_error
    vecs[11] = '{1, 4'h1, 0, 1, 1, 0, 8'h00, 4'h0, 0, 0, 8'd4};
    vecs[12] = '{1, 4'h2, 1, 1, 1, 1, 8'h12, 4'h3, 1, 0, 8'd4};
    vecs[13] = '{1, 4'h6, 1, 1, 1, 0, 8'h00, 4'h0, 0, 1, 8'd5};
    vecs[14] = '{0, 4'h0, 0, 1, 1, 0, 8'h00, 4'h0, 0, 0, 8'd5};

    srst = 1'b1; in_valid = 1'b0; in_nibble = 4'h0; in_last = 1'b0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'd0);
    check("reset out_byte_a", 16'(out_byte_a), 16'h00);
    check("reset out_sum_a", 16'(out_sum_a), 16'h0);
    check("reset out_last_a", 16'(out_last_a), 16'h0);
    @(negedge clk);
    srst = 1'b0;
    #1;
    check("reset in_ready_a", 16'(in_ready_a), 16'h1);
    $display("reset: ov=%0d byte=%h cnt=%0d", out_valid_a, out_byte_a, byte_count_a);

    for (int i = 0; i < 15; i++) begin
      step($sformatf("vec%0d", i), vecs[i].v, vecs[i].n, vecs[i].l, vecs[i].r, vecs[i].ir,
           vecs[i].ov, vecs[i].b, vecs[i].s, vecs[i].lst, vecs[i].odd, vecs[i].cnt);
    end

    // Reset with a stalled byte pending and a nibble held in WAIT_SECOND.
    step("mid0", 1, 4'h4, 0, 0, 1, 0, 8'h00, 4'h0, 0, 0, 8'd5);
    step("mid1", 1, 4'hB, 0, 0, 1, 1, 8'h4B, 4'hF, 0, 0, 8'd5);
    step("mid2", 1, 4'h2, 0, 0, 1, 1, 8'h4B, 4'hF, 0, 0, 8'd5);
    @(negedge clk);
    srst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(posedge clk);
    #1;
    check_outputs("midrst", 1'b0, 8'h00, 4'h0, 1'b0, 1'b0, 8'd0);
    check("midrst out_byte_a", 16'(out_byte_a), 16'h00);
    check("midrst out_sum_a", 16'(out_sum_a), 16'h0);
    check("midrst out_last_a", 16'(out_last_a), 16'h0);
    $display("midrst: ov=%0d byte=%h cnt=%0d", out_valid_a, out_byte_a, byte_count_a);
    @(negedge clk);
    srst = 1'b0;
    // Held nibble 2 must be gone: E,1 forms a fresh pair.
    step("post0", 1, 4'hE, 0, 1, 1, 0, 8'h00, 4'h0, 0, 0, 8'd0);
    step("post1", 1, 4'h1, 1, 1, 1, 1, 8'hE1, 4'hF, 1, 0, 8'd0);
    step("post2", 0, 4'h0, 0, 1, 1, 0, 8'h00, 4'h0, 0, 0, 8'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net in case the stimulus ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish in time");
    $fatal(1, "timeout");
  end

endmodule
